// File: rtl/param_pipe_csla_pkg.sv
// Shared constants for the pipelined carry-select adder.
// Approximation modes and per-segment mode selection.
package param_pipe_csla_pkg;

    localparam int APPROX_EXACT = 0;
    localparam int APPROX_LOA   = 1;

    function automatic int seg_mode(
        input int k,
        input int approx,
        input int approx_blks
    );
        return (k < approx_blks) ? approx : APPROX_EXACT;
    endfunction

endpackage

// File: rtl/param_pipe_csla_if.sv
// Valid/ready bundle between the adder and its producer/consumer.
// master drives operands and out_ready; slave is the adder.
interface param_pipe_csla_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/param_pipe_csla_seg.sv
// Ripple adder (exact or lower-part-OR) and the carry-select segment
// that precomputes both carry-in outcomes for one block.
module param_rca
    import param_pipe_csla_pkg::*;
#(
    parameter int W      = 4,
    parameter int APPROX = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    generate
        if (APPROX == APPROX_LOA) begin : g_loa
            // OR replaces addition; carry is guessed from the top bit pair
            always_comb begin
                s    = a | b;
                s[0] = a[0] | b[0] | cin;
                cout = a[W-1] & b[W-1];
            end
        end else begin : g_exact
            assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
    endgenerate
endmodule

module csla_seg #(
    parameter int BLK    = 4,
    parameter int APPROX = 0
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    output logic [BLK-1:0] s0,
    output logic           c0,
    output logic [BLK-1:0] s1,
    output logic           c1
);
    param_rca #(.W(BLK), .APPROX(APPROX)) u_rca0 (
        .a(a), .b(b), .cin(1'b0), .s(s0), .cout(c0)
    );

    param_rca #(.W(BLK), .APPROX(APPROX)) u_rca1 (
        .a(a), .b(b), .cin(1'b1), .s(s1), .cout(c1)
    );
endmodule

// File: rtl/param_pipe_csla.sv
// Two-stage carry-select adder: S1 registers per-segment sum/carry pairs,
// S2 resolves the select chain and registers sum/cout.
module param_pipe_csla
    import param_pipe_csla_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int BLK         = 4,
    parameter int APPROX      = 0,
    parameter int APPROX_BLKS = 0
) (
    input logic               clk,
    input logic               rst,
    param_pipe_csla_if.slave  bus
);
    localparam int NBLK = WIDTH / BLK;

    generate
        if (BLK < 1 || BLK > WIDTH || (WIDTH % BLK) != 0) begin : g_bad_blk
            $error("param_pipe_csla: WIDTH must be a multiple of BLK");
        end
        if (APPROX_BLKS < 0 || APPROX_BLKS > NBLK) begin : g_bad_apx
            $error("param_pipe_csla: APPROX_BLKS out of range");
        end
    endgenerate

    logic [NBLK-1:0][BLK-1:0] s0_d, s1_d, s0_q, s1_q;
    logic [NBLK-1:0]          c0_d, c1_d, c0_q, c1_q;
    logic                     cin_q;
    logic                     s1_valid, out_valid;
    logic                     adv1, adv2;
    logic                     sel;
    logic [WIDTH-1:0]         sum_d, sum_q;
    logic                     cout_d, cout_q;

    for (genvar k = 0; k < NBLK; k++) begin : g_seg
        csla_seg #(
            .BLK   (BLK),
            .APPROX(seg_mode(k, APPROX, APPROX_BLKS))
        ) u_seg (
            .a (bus.a[k*BLK +: BLK]),
            .b (bus.b[k*BLK +: BLK]),
            .s0(s0_d[k]),
            .c0(c0_d[k]),
            .s1(s1_d[k]),
            .c1(c1_d[k])
        );
    end

    assign adv2 = !out_valid || bus.out_ready;
    assign adv1 = !s1_valid || adv2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (adv1) s1_valid  <= bus.in_valid;
            if (adv2) out_valid <= s1_valid;
        end
    end

    // S1 data needs no reset: it is never observed without s1_valid
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            c0_q  <= c0_d;
            c1_q  <= c1_d;
            cin_q <= bus.cin;
        end
    end

    always_comb begin
        sum_d = '0;
        sel   = cin_q;
        for (int k = 0; k < NBLK; k++) begin
            sum_d[k*BLK +: BLK] = sel ? s1_q[k] : s0_q[k];
            sel                 = sel ? c1_q[k] : c0_q[k];
        end
        cout_d = sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (adv2 && s1_valid) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = s1_valid || out_valid;
endmodule

// File: tb/tb_param_pipe_csla.sv
// Scoreboard bench: exact adder plus a one-segment approximate twin
// fed the same traffic.
module tb_param_pipe_csla;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    param_pipe_csla_if #(.WIDTH(W)) bus ();
    param_pipe_csla_if #(.WIDTH(W)) abus ();

    param_pipe_csla #(
        .WIDTH(W), .BLK(4), .APPROX(0), .APPROX_BLKS(0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    param_pipe_csla #(
        .WIDTH(W), .BLK(4), .APPROX(1), .APPROX_BLKS(1)
    ) dut_ax (
        .clk(clk), .rst(rst), .bus(abus)
    );

    assign abus.in_valid  = bus.in_valid;
    assign abus.a         = bus.a;
    assign abus.b         = bus.b;
    assign abus.cin       = bus.cin;
    assign abus.out_ready = bus.out_ready;

    res_t exp_q[$];
    op_t  ax_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    int   n_ax   = 0;
    int   ax_diff = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t",
                     name, got, want, $time);
        end
    endtask

    function automatic res_t ref_add(input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic cin);
        int unsigned t;
        res_t r;
        t      = int'(a) + int'(b) + int'(cin);
        r.sum  = W'(t % 65536);
        r.cout = (t >= 65536);
        return r;
    endfunction

    // exact scoreboard
    always @(negedge clk) begin
        res_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum=%0h, expected none",
                         bus.sum);
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(bus.sum), 32'(e.sum));
                check("cout", 32'(bus.cout), 32'(e.cout));
            end
        end
    end

    // approximate twin: upper 12 bits must be a+b for some seg-0 carry
    always @(negedge clk) begin
        op_t o;
        int unsigned hi, got;
        res_t e;
        if (!rst && abus.out_valid && abus.out_ready) begin
            n_ax++;
            if (ax_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ax_unexpected: got sum=%0h, expected none",
                         abus.sum);
            end else begin
                o   = ax_q.pop_front();
                e   = ref_add(o.a, o.b, o.cin);
                hi  = int'(o.a[W-1:4]) + int'(o.b[W-1:4]);
                got = {19'd0, abus.cout, abus.sum[W-1:4]};
                check("ax_upper", 32'(got == hi || got == hi + 1), 32'd1);
                if (abus.sum[W-1:4] != e.sum[W-1:4]) ax_diff++;
            end
        end
    end

    // a stalled output must hold
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_sum", 32'(bus.sum), 32'(prev_sum));
                check("hold_cout", 32'(bus.cout), 32'(prev_cout));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.sum;
            prev_cout  = bus.cout;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int stalls);
        logic acc;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        stalls       = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            if (!acc) stalls++;
        end while (!acc && stalls < 50);
        if (acc) begin
            exp_q.push_back(ref_add(a, b, cin));
            ax_q.push_back('{a: a, b: b, cin: cin});
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected one in 50");
        end
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected one");
        $fatal(1, "timeout");
    end

    initial begin
        int st, tot, c0, o0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // full carry ripple, latency and single-cycle valid
        send(16'hFFFF, 16'h0001, 1'b0, st);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_s1_valid", 32'(bus.out_valid), 32'd0);
        check("lat_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("lat_s2_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("lat_one_cycle", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        send(16'h0F0F, 16'hF0F0, 1'b1, st);
        idle(4);

        // back-to-back random stream
        tot = 0;
        c0  = cyc;
        o0  = n_out;
        for (int i = 0; i < 1000; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), st);
            tot += st;
        end
        check("stream_stalls", 32'(tot), 32'd0);
        check("stream_cycles", 32'(cyc - c0), 32'd1000);
        idle(4);
        check("stream_outputs", 32'(n_out - o0), 32'd1000);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // backpressure
        bus.out_ready = 1'b0;
        send(16'd1, 16'd2, 1'b0, st);
        send(16'd3, 16'd4, 1'b0, st);
        fork
            begin
                int st3;
                send(16'd5, 16'd6, 1'b0, st3);
                bus.in_valid = 1'b0;
            end
            begin
                @(negedge clk);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_valid", 32'(bus.out_valid), 32'd1);
                check("bp_sum", 32'(bus.sum), 32'd3);
                repeat (3) @(negedge clk);
                check("bp_in_ready_late", 32'(bus.in_ready), 32'd0);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_drain_valid", 32'(bus.out_valid), 32'd1);
                end
                @(negedge clk);
                check("bp_drain_done", 32'(bus.out_valid), 32'd0);
            end
        join
        idle(2);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // asynchronous reset with two results in flight
        send(16'd1, 16'd1, 1'b0, st);
        send(16'd2, 16'd2, 1'b0, st);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        exp_q.delete();
        ax_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("approx segment: %0d of %0d results differ from exact",
                 ax_diff, n_ax);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
